// File: rtl/tmds_decoder.sv
// Receive-side TMDS channel decoder: two-stage symbol decode plus a word-alignment
// FSM that hunts for control-token runs and steers the deserialiser bitslip.
module tmds_decoder #(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 8,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_tmds,
    output logic [7:0] o_pixel,
    output logic [1:0] o_ctrl,
    output logic       o_de,
    output logic       o_locked,
    output logic       o_bitslip
);

    localparam int RUN_W   = $clog2(CTRL_RUN + 1);
    localparam int TMO_MAX = (SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT : LOCK_TIMEOUT;
    localparam int TMO_W   = (TMO_MAX > 1) ? $clog2(TMO_MAX) : 1;
    localparam int SW_W    = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    localparam logic [9:0] TokC0 = 10'b1101010100;
    localparam logic [9:0] TokC1 = 10'b0010101011;
    localparam logic [9:0] TokC2 = 10'b0101010100;
    localparam logic [9:0] TokC3 = 10'b1010101011;

    localparam logic [1:0] StSearch = 2'd0;
    localparam logic [1:0] StSlip   = 2'd1;
    localparam logic [1:0] StLocked = 2'd2;

    logic [9:0]       tmds_q, tmds_d;
    logic             tok_q, tok_d;
    logic [7:0]       pixel_q, pixel_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             de_q, de_d;
    logic [1:0]       state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [SW_W-1:0]  sw_q, sw_d;
    logic             bitslip_q, bitslip_d;

    logic       run_event;
    logic       run_clr;
    logic       locked;
    logic [7:0] q;
    logic [7:0] dec;
    logic [1:0] ctrl_dec;

    assign locked    = (state_q == StLocked);
    assign run_event = tok_q && (run_q == RUN_W'(CTRL_RUN - 1));

    // Stage 1: capture the raw symbol and whether it is one of the four control tokens.
    always_comb begin
        tmds_d = i_tmds;
        tok_d  = (i_tmds == TokC0) || (i_tmds == TokC1) ||
                 (i_tmds == TokC2) || (i_tmds == TokC3);
    end

    // Stage 2: undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        q      = tmds_q[9] ? ~tmds_q[7:0] : tmds_q[7:0];
        dec    = 8'h00;
        dec[0] = q[0];
        for (int n = 1; n < 8; n++) begin
            dec[n] = tmds_q[8] ? (q[n] ^ q[n-1]) : ~(q[n] ^ q[n-1]);
        end

        case (tmds_q)
            TokC0:   ctrl_dec = 2'b00;
            TokC1:   ctrl_dec = 2'b01;
            TokC2:   ctrl_dec = 2'b10;
            TokC3:   ctrl_dec = 2'b11;
            default: ctrl_dec = ctrl_q;
        endcase

        pixel_d = tok_q ? pixel_q : dec;
        ctrl_d  = tok_q ? ctrl_dec : ctrl_q;
        de_d    = !tok_q && locked;
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        sw_d      = sw_q;
        bitslip_d = 1'b0;
        run_clr   = 1'b0;
        case (state_q)
            StSearch: begin
                if (run_event) begin
                    state_d = StLocked;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_W'(SEARCH_TIMEOUT - 1)) begin
                    state_d   = StSlip;
                    tmo_d     = '0;
                    sw_d      = '0;
                    bitslip_d = 1'b1;
                    run_clr   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StSlip: begin
                // Deserialiser output is unreliable while it settles; count nothing.
                tmo_d   = '0;
                run_clr = 1'b1;
                if (sw_q == SW_W'(SLIP_WAIT - 1)) begin
                    state_d = StSearch;
                end else begin
                    sw_d = sw_q + 1'b1;
                end
            end
            StLocked: begin
                if (run_event) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = StSearch;
                    tmo_d   = '0;
                    run_clr = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = StSearch;
                tmo_d   = '0;
                run_clr = 1'b1;
            end
        endcase
    end

    // Saturating run length; the event fires only on the transition into CTRL_RUN.
    always_comb begin
        if (run_clr || !tok_q) begin
            run_d = '0;
        end else if (run_q != RUN_W'(CTRL_RUN)) begin
            run_d = run_q + 1'b1;
        end else begin
            run_d = run_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmds_q    <= '0;
            tok_q     <= 1'b0;
            pixel_q   <= '0;
            ctrl_q    <= '0;
            de_q      <= 1'b0;
            state_q   <= StSearch;
            run_q     <= '0;
            tmo_q     <= '0;
            sw_q      <= '0;
            bitslip_q <= 1'b0;
        end else begin
            tmds_q    <= tmds_d;
            tok_q     <= tok_d;
            pixel_q   <= pixel_d;
            ctrl_q    <= ctrl_d;
            de_q      <= de_d;
            state_q   <= state_d;
            run_q     <= run_d;
            tmo_q     <= tmo_d;
            sw_q      <= sw_d;
            bitslip_q <= bitslip_d;
        end
    end

    assign o_pixel   = pixel_q;
    assign o_ctrl    = ctrl_q;
    assign o_de      = de_q;
    assign o_locked  = locked;
    assign o_bitslip = bitslip_q;

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
- Receive-side TMDS channel decoder for the HDMI sink path. Consumes one parallel 10-bit TMDS symbol per pixel clock from the deserialiser and recovers pixel data, control bits and data-enable.
- Contains a word-alignment FSM. The FSM looks for runs of control tokens during blanking, requests bitslips from the deserialiser until a run is found, and reports lock.
- One instance per TMDS channel (blue, green, red).

Parameters:
- CTRL_RUN, 8, consecutive control tokens required to declare alignment.
- SEARCH_TIMEOUT, 4096, cycles in SEARCH without a qualifying run before a bitslip is requested.
- SLIP_WAIT, 8, cycles to ignore input after a bitslip pulse (deserialiser settling).
- LOCK_TIMEOUT, 4096, cycles in LOCKED without a qualifying run before lock is dropped.

Ports:
- i_clk  input  1  pixel clock
- i_rst  input  1  synchronous reset, active-high
- i_tmds  input  10  deserialised TMDS symbol, bit 0 first on the wire
- o_pixel  output  8  decoded pixel data
- o_ctrl  output  2  decoded control bits {c1,c0}
- o_de  output  1  pixel data valid (data period); forced 0 while not locked
- o_locked  output  1  word alignment achieved
- o_bitslip  output  1  one-cycle request to the deserialiser to shift word boundary by one bit

Behaviour:
- Reset (i_clk edge with i_rst=1): all outputs 0, FSM to SEARCH, all counters 0. Reset mid-operation takes effect on the next edge, regardless of state.
- Pipeline: stage 1 registers i_tmds and a control-token match flag. Stage 2 registers o_pixel, o_ctrl and o_de. Latency from i_tmds to outputs is exactly 2 cycles.
- Control tokens:
  - 1101010100 decodes to ctrl 00.
  - 0010101011 decodes to ctrl 01.
  - 0101010100 decodes to ctrl 10.
  - 1010101011 decodes to ctrl 11.
  - On a match: o_de=0, o_ctrl=decoded value, o_pixel holds its previous value.
- Data symbols (any non-token symbol):
  - q[7:0] = tmds[9] ? ~tmds[7:0] : tmds[7:0].
  - d[0] = q[0].
  - For n=1..7: d[n] = tmds[8] ? q[n]^q[n-1] : ~(q[n]^q[n-1]).
  - Outputs: o_pixel=d, o_de=locked, o_ctrl holds its previous value.
- Run counter:
  - Counts consecutive stage-1 control-token matches; any data symbol clears it to 0.
  - Saturates at CTRL_RUN.
  - A "qualifying run" event fires on the cycle the counter reaches CTRL_RUN.
  - Run counter, timeout counter and slip-wait counter are each sized to their parameter via $clog2.
- FSM states:
  - SEARCH:
    - A qualifying run moves the FSM to LOCKED (o_locked=1 on the next cycle).
    - Otherwise the timeout counter increments each cycle. On reaching SEARCH_TIMEOUT-1, o_bitslip pulses high for exactly 1 cycle, the timeout counter clears, and the FSM moves to SLIP.
  - SLIP:
    - Waits SLIP_WAIT cycles; run and timeout counters are held at 0.
    - Then returns to SEARCH.
    - o_bitslip=0 throughout.
  - LOCKED:
    - Each qualifying run clears the timeout counter. Once the counter saturates at CTRL_RUN, further tokens do not re-fire the event; the next run must follow a data symbol.
    - On reaching LOCK_TIMEOUT-1 with no run: o_locked falls, and the FSM moves to SEARCH with counters cleared.
    - No bitslip is issued on that transition.
- Simultaneous events: a qualifying run on the same cycle the timeout expires takes priority. In SEARCH it locks with no slip; in LOCKED it stays locked.
- o_de is gated combinationally-free: the stage-2 register captures (data symbol AND o_locked-state). As a result o_de is 0 from the first stage-2 cycle after lock loss.

Test Plan:
- Reset: assert i_rst 3 cycles with i_tmds=0x1F0 -> all outputs 0. Release -> o_locked=0, o_bitslip=0.
- Token decode: after lock, drive 1101010100, 0010101011, 0101010100, 1010101011 -> o_ctrl=00,01,10,11 two cycles later, o_de=0.
- Data decode, locked:
  - 0x1F0 -> o_pixel=0x10, o_de=1 after 2 cycles.
  - 0x30F -> o_pixel=0x10.
  - Sweep all 256 pixels through a reference encoder with random DE/ctrl -> outputs match input delayed 2 cycles.
- Lock acquisition: 7 tokens then data -> no lock. 8 consecutive tokens -> o_locked=1. Data while unlocked -> o_de=0.
- Bitslip: feed a stream misaligned by 3 bits, with a model deserialiser that shifts by 1 on each o_bitslip -> pulses every SEARCH_TIMEOUT+SLIP_WAIT cycles, exactly 3 pulses, then lock.
- Lock loss and edges:
  - In LOCKED, data-only stream for LOCK_TIMEOUT cycles -> o_locked falls, no bitslip.
  - Run completing on the timeout cycle -> lock retained.
  - i_rst asserted in SLIP -> SEARCH, o_bitslip=0.
